// File: rtl/lau_pkg.sv
// lau_pkg: shared types for the arithmetic unit library.
//   speed_e     - implementation choice for the Add adder (ripple vs. native '+').
//   acc_state_e - state encoding of the acc_stream burst FSM.
package lau_pkg;

    typedef enum logic {
        SLOW = 1'b0,
        FAST = 1'b1
    } speed_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // accumulator empty
        ACC  = 2'd1,   // burst in progress
        HOLD = 2'd2    // result valid, waiting to be taken
    } acc_state_e;

endpackage

// File: rtl/acc_stream_add.sv
// Add: combinational unsigned adder, S = A + B modulo 2^width.
// Parameters:
//   width - operand/result width
//   speed - FAST uses the native '+' operator, SLOW a bit-serial ripple chain
// Ports:
//   A, B (in, width) operands
//   S    (out, width) sum, carry-out dropped
module Add
    import lau_pkg::*;
#(
    parameter int unsigned width = 16,
    parameter speed_e      speed = FAST
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic [width-1:0] S
);

    generate
        if (speed == FAST) begin : g_fast
            assign S = A + B;
        end else begin : g_slow
            logic [width-1:0] ripple_sum;
            logic             carry;

            // Carry is a block-local running value so no bit of a vector
            // feeds back into another bit of the same vector.
            always_comb begin
                carry      = 1'b0;
                ripple_sum = '0;
                for (int i = 0; i < int'(width); i++) begin
                    ripple_sum[i] = A[i] ^ B[i] ^ carry;
                    carry         = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
                end
            end

            assign S = ripple_sum;
        end
    endgenerate

endmodule

// File: rtl/acc_stream.sv
// acc_stream: streaming accumulator. Sums a burst of unsigned operands
// received over a valid/ready input into a registered accumulator and
// presents the total, the beat count and a sticky overflow flag over a
// valid/ready output.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready and, once raised, stays high with
// stable data until the transfer. ready_o is the one combinational path
// (ready_i -> ready_o) so a new burst can start in the same cycle the
// previous result is taken.
//
// Build option: define LAU_ACC_SATURATE_EN to clamp the sum to all-ones on
// carry-out instead of wrapping. ovf_o reports carry-out in both builds.
//
// Parameters: width (data width), speed (forwarded to Add), cntWidth (beat
// counter width; bursts longer than 2^cntWidth-1 beats are cut there).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   valid_i, ready_o   operand handshake
//   A, last_i          operand and end-of-burst marker
//   valid_o, ready_i   result handshake
//   S, cnt_o, ovf_o    sum, beat count, sticky overflow (registered)
//   dbg_state          current FSM state, for observation only
module acc_stream
    import lau_pkg::*;
#(
    parameter int unsigned width    = 16,
    parameter speed_e      speed    = FAST,
    parameter int unsigned cntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [width-1:0]    A,
    input  logic                last_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [width-1:0]    S,
    output logic [cntWidth-1:0] cnt_o,
    output logic                ovf_o,
    output acc_state_e          dbg_state
);

    localparam logic [cntWidth-1:0] CNT_MAX = '1;
    localparam logic [cntWidth-1:0] CNT_ONE = cntWidth'(1);

    acc_state_e          state;
    logic                beat;
    logic                first_beat;
    logic                is_last;
    logic                carry;
    logic                ovf_next;
    logic [width-1:0]    b;
    logic [width-1:0]    sum;
    logic [width-1:0]    sum_next;
    logic [cntWidth-1:0] cnt_next;

    assign ready_o   = (state != HOLD) | ready_i;
    assign beat      = valid_i & ready_o;
    // Outside ACC any accepted beat opens a new burst (in HOLD it can only be
    // accepted together with the result being taken).
    assign first_beat = (state != ACC);
    assign b          = first_beat ? '0 : S;

    Add #(
        .width(width),
        .speed(speed)
    ) adder (
        .A(A),
        .B(b),
        .S(sum)
    );

    // Carry-out recovered from the MSB of operands and sum.
    assign carry = (A[width-1] & b[width-1]) |
                   ((A[width-1] | b[width-1]) & ~sum[width-1]);

    assign cnt_next = first_beat ? CNT_ONE : cnt_o + CNT_ONE;
    // The beat that would fill the counter closes the burst, so it never wraps.
    assign is_last  = last_i | (cnt_next == CNT_MAX);
    assign ovf_next = first_beat ? carry : (ovf_o | carry);

`ifdef LAU_ACC_SATURATE_EN
    // Once saturated, S is all-ones and any further add carries again
    // (or adds zero), so the clamp holds for the rest of the burst.
    assign sum_next = carry ? '1 : sum;
`else
    assign sum_next = sum;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            S       <= '0;
            cnt_o   <= '0;
            ovf_o   <= 1'b0;
        end else if (beat) begin
            state   <= is_last ? HOLD : ACC;
            valid_o <= is_last;
            S       <= sum_next;
            cnt_o   <= cnt_next;
            ovf_o   <= ovf_next;
        end else if (state == HOLD && ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_acc_stream.sv
// Bench for acc_stream: directed scenarios followed by randomized bursts
// scored against a burst-level arithmetic model.
module tb_acc_stream;
    import lau_pkg::*;

    localparam int W  = 16;
    localparam int CW = 8;
    localparam int EW = 1 + CW + W;   // {ovf, cnt, sum}
    localparam int N_BURST = 40;

    logic          clk_i;
    logic          rst_ni;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  a;
    logic          last_i;
    logic          valid_o;
    logic          ready_i;
    logic [W-1:0]  s;
    logic [CW-1:0] cnt_o;
    logic          ovf_o;
    acc_state_e    dbg_state;

    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    acc_stream #(
        .width(W),
        .speed(FAST),
        .cntWidth(CW)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .A(a),
        .last_i(last_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .S(s),
        .cnt_o(cnt_o),
        .ovf_o(ovf_o),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: a burst's result follows from its operand total and length.
    function automatic logic [EW-1:0] model(input longint unsigned total, input int n);
        logic          ov;
        logic [W-1:0]  sm;
        logic [CW-1:0] c;
        longint unsigned wrapped;
        ov      = (total > 64'd65535);
        wrapped = total % 65536;
        sm      = W'(wrapped);
`ifdef LAU_ACC_SATURATE_EN
        if (ov) sm = '1;
`endif
        c = CW'(n);
        return {ov, c, sm};
    endfunction

    // ---------------- driver ----------------
    // Presents one beat from just after a rising edge and returns just after
    // the edge that accepted it.
    task automatic send_beat(input logic [W-1:0] val, input logic last);
        int waited;
        waited = 0;
        @(posedge clk_i); #1;
        valid_i = 1'b1;
        a       = val;
        last_i  = last;
        @(negedge clk_i);
        while (!ready_o && waited < 500) begin
            waited++;
            @(negedge clk_i);
        end
        if (waited >= 500) check("beat_timeout", 32'(waited), 32'd0);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] es,
                                input logic [CW-1:0] ec, input logic eo);
        @(negedge clk_i);
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
        check({tag, "_sum"},   32'(s),       32'(es));
        check({tag, "_cnt"},   32'(cnt_o),   32'(ec));
        check({tag, "_ovf"},   32'(ovf_o),   32'(eo));
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b1;
        a       = 16'd5;
        last_i  = 1'b1;
        ready_i = 1'b1;

        // Reset with valid held high: nothing may be captured.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_hold_valid", 32'(valid_o), 32'd0);
        check("rst_hold_sum",   32'(s),       32'd0);
        @(posedge clk_i); #1;
        rst_ni  = 1'b1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        @(negedge clk_i);
        check("rst_ready", 32'(ready_o),   32'd1);
        check("rst_valid", 32'(valid_o),   32'd0);
        check("rst_sum",   32'(s),         32'd0);
        check("rst_cnt",   32'(cnt_o),     32'd0);
        check("rst_ovf",   32'(ovf_o),     32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // Overflow across a burst.
        send_beat(16'hFFF0, 1'b0);
        send_beat(16'h0020, 1'b1);
`ifdef LAU_ACC_SATURATE_EN
        check_result("ovf_burst", 16'hFFFF, 8'd2, 1'b1);
`else
        check_result("ovf_burst", 16'h0010, 8'd2, 1'b1);
`endif

        // Plain burst; overflow from the previous burst must be cleared.
        send_beat(16'd3, 1'b0);
        send_beat(16'd5, 1'b0);
        send_beat(16'd7, 1'b1);
        check_result("sum3", 16'd15, 8'd3, 1'b0);

        // Result held by back-pressure, then taken together with a new beat.
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        send_beat(16'd1, 1'b0);
        send_beat(16'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("hold_ready", 32'(ready_o), 32'd0);
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_sum",   32'(s),       32'd3);
            check("hold_cnt",   32'(cnt_o),   32'd2);
        end
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        valid_i = 1'b1;
        a       = 16'd9;
        last_i  = 1'b1;
        @(negedge clk_i);
        check("hold_release_ready", 32'(ready_o), 32'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        check_result("back2back", 16'd9, 8'd1, 1'b0);

        // Counter limit: beat 255 closes the burst, the next beat opens a new one.
        for (int i = 0; i < 255; i++) send_beat(16'd1, 1'b0);
        check_result("cnt_limit", 16'd255, 8'd255, 1'b0);
        send_beat(16'd6, 1'b0);
        @(negedge clk_i);
        check("after_limit_valid", 32'(valid_o), 32'd0);
        check("after_limit_cnt",   32'(cnt_o),   32'd1);
        check("after_limit_sum",   32'(s),       32'd6);
        send_beat(16'd1, 1'b1);
        check_result("after_limit", 16'd7, 8'd2, 1'b0);

        // Reset mid-burst discards the partial sum.
        send_beat(16'd2, 1'b0);
        send_beat(16'd3, 1'b0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst_valid", 32'(valid_o),   32'd0);
        check("midrst_sum",   32'(s),         32'd0);
        check("midrst_cnt",   32'(cnt_o),     32'd0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("midrst_novalid", 32'(valid_o), 32'd0);
        send_beat(16'd4, 1'b1);
        check_result("midrst_next", 16'd4, 8'd1, 1'b0);

        // Randomized bursts with random back-pressure.
        fork
            begin : drv
                for (int n = 0; n < N_BURST; n++) begin
                    int len;
                    longint unsigned total;
                    logic [W-1:0] ops[$];
                    len   = $urandom_range(1, 6);
                    total = 0;
                    ops   = {};
                    for (int k = 0; k < len; k++) begin
                        logic [W-1:0] v;
                        if ($urandom_range(0, 3) == 0) v = W'($urandom_range(16'hC000, 16'hFFFF));
                        else v = W'($urandom_range(0, 16'h0FFF));
                        ops.push_back(v);
                        total += longint'(v);
                    end
                    exp_q.push_back(model(total, len));
                    for (int k = 0; k < len; k++) send_beat(ops[k], k == len - 1);
                    repeat ($urandom_range(0, 2)) @(posedge clk_i);
                end
            end
            begin : snk
                int got;
                int cyc;
                logic [EW-1:0] e;
                got = 0;
                cyc = 0;
                while (got < N_BURST && cyc < 20000) begin
                    @(posedge clk_i); #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                    @(negedge clk_i);
                    cyc++;
                    if (valid_o) begin
                        if (exp_q.size() == 0) begin
                            check("rand_spurious", 32'(valid_o), 32'd0);
                        end else begin
                            e = exp_q[0];
                            check("rand_sum", 32'(s),     32'(e[W-1:0]));
                            check("rand_cnt", 32'(cnt_o), 32'(e[W+CW-1:W]));
                            check("rand_ovf", 32'(ovf_o), 32'(e[EW-1]));
                            if (ready_i) begin
                                void'(exp_q.pop_front());
                                got++;
                            end
                        end
                    end
                end
                if (got < N_BURST) check("rand_timeout", 32'(got), 32'(N_BURST));
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acc_stream.md
# acc_stream

Streaming accumulator built around the `Add` adder. It accepts a burst of `width`-bit unsigned operands over a valid/ready handshake and sums them into a registered accumulator. The final sum is presented on a valid/ready output, together with the operand count and a sticky overflow flag. The accumulator register is the sequential stage that feeds `Add` one operand and consumes its sum every accepted beat.

## Interface
- `width`, 16: operand, accumulator and result word width.
- `speed`, `lau_pkg::FAST`: passed unchanged to the internal `Add`.
- `cntWidth`, 8: width of the beat counter; a burst may hold at most 2^cntWidth − 1 beats.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  operand valid.
- `ready_o`  out  1  operand ready.
- `A`  in  width  operand.
- `last_i`  in  1  marks the final beat of a burst; sampled with `A`.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  result ready.
- `S`  out  width  accumulated sum.
- `cnt_o`  out  cntWidth  number of beats in the burst.
- `ovf_o`  out  1  sticky unsigned overflow (or saturation) seen during the burst.

## Operation
- A beat is accepted when `valid_i & ready_o`. A result is taken when `valid_o & ready_i`.
- States (`acc_state_e`):
  - IDLE: accumulator empty.
  - ACC: burst in progress.
  - HOLD: result valid.
- Adder operand B:
  - B = 0 on the first beat of a burst (IDLE, or HOLD with `ready_i`).
  - Otherwise B = accumulator.
  - Sum register ← `Add(A, B)` on every accepted beat.
- Carry-out is derived as bit `width-1` of `(A & B) | ((A | B) & ~sum)`. It sets the overflow register.
- Transitions:
  - IDLE → ACC on an accepted beat without `last_i`.
  - IDLE → HOLD on an accepted beat with `last_i`.
  - ACC → ACC on an accepted beat without `last_i`.
  - ACC → HOLD on an accepted beat with `last_i`.
  - HOLD → IDLE on result taken with no new beat.
  - HOLD → ACC or HOLD (new burst, first-beat rules) when the result is taken and a beat is accepted in the same cycle.
- Counter:
  - Loads 1 on the first beat; increments on each further beat.
  - Beat number 2^cntWidth − 1 is forced to behave as `last_i` = 1, so the counter never wraps.
- `ovf_o` clears on the first beat of a new burst and is sticky within the burst.
- `S`, `cnt_o` and `ovf_o` are direct register outputs. They stay stable while `valid_o & ~ready_i`.

## Timing
- Reset values:
  - state = IDLE, `valid_o` = 0.
  - `S` = 0, `cnt_o` = 0, `ovf_o` = 0.
  - `ready_o` = 1 once `rst_ni` is high.
- Latency: `valid_o` rises in the cycle after the `last_i` beat is accepted.
- `ready_o` = (state ≠ HOLD) | `ready_i`. This combinational `ready_i`→`ready_o` path gives full throughput with no bubble between bursts.
- `valid_o` does not depend on `ready_i`. Once asserted, it holds until the result is taken.
- Reset asserted mid-burst discards the partial sum immediately; no result is emitted.
- Single-beat burst (first beat with `last_i`): `S` = `A`, `cnt_o` = 1.

## Configuration
- Macro: `LAU_ACC_SATURATE_EN`.
- Defined:
  - On carry-out, the sum register loads all-ones instead of the wrapped sum, and `ovf_o` sets.
  - Later beats in the same burst keep the sum at all-ones.
- Undefined:
  - The sum wraps modulo 2^width; `ovf_o` still sets on carry-out.
  - No saturation logic is instantiated.

## Structure
- `lau_pkg` gains:
  - `acc_state_e` (IDLE, ACC, HOLD), a 2-bit enum.
  - No new constants.
- Exactly one sub-module: `Add` (instance `adder`), with `width` and `speed` forwarded.
- Everything else (FSM, counter, overflow and saturation mux) is local to `acc_stream`.

## Test plan
- Reset with `valid_i` held high → all outputs 0 and `ready_o` = 1 one cycle after `rst_ni` rises; no beat is accepted while `rst_ni` = 0.
- width=16, beats 3, 5, 7 (last on 7), `ready_i` = 1 → next cycle `valid_o` = 1, `S` = 15, `cnt_o` = 3, `ovf_o` = 0.
- width=16, beats 0xFFF0, 0x0020 (last):
  - Without macro → `S` = 0x0010, `ovf_o` = 1.
  - With `LAU_ACC_SATURATE_EN` → `S` = 0xFFFF, `ovf_o` = 1.
- Result held with `ready_i` = 0 for 4 cycles → `ready_o` = 0 and `S`/`cnt_o` stable. Then raise `ready_i` with a new beat 9 (last) in the same cycle → that beat is accepted, and the next result is `S` = 9, `cnt_o` = 1.
- cntWidth=2, four beats of 1 with no `last_i` → result after the third beat: `S` = 3, `cnt_o` = 3. The fourth beat starts a new burst.
- Reset pulsed after two beats of a burst → no `valid_o`. A following single beat 4 (last) yields `S` = 4.
